// File: rtl/regfile_wrport.sv
// regfile_wrport: ARM R0..R15 write side with A/B writeback arbitration, B starvation guard, PC+4; REGWR_WRITETHRU_EN adds same-cycle forwarding
module regfile_wrport #(
  parameter int BITWIDTH = 32,
  parameter logic [BITWIDTH-1:0] RESET_PC = '0,
  parameter int MAX_STALL = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                A_VALID,
  output logic                A_READY,
  input  logic [3:0]          A_ADDR,
  input  logic [BITWIDTH-1:0] A_DATA,
  input  logic                B_VALID,
  output logic                B_READY,
  input  logic [3:0]          B_ADDR,
  input  logic [BITWIDTH-1:0] B_DATA,
  input  logic                PC_INC,
  output logic [BITWIDTH-1:0] OUT0,
  output logic [BITWIDTH-1:0] OUT1,
  output logic [BITWIDTH-1:0] OUT2,
  output logic [BITWIDTH-1:0] OUT3,
  output logic [BITWIDTH-1:0] OUT4,
  output logic [BITWIDTH-1:0] OUT5,
  output logic [BITWIDTH-1:0] OUT6,
  output logic [BITWIDTH-1:0] OUT7,
  output logic [BITWIDTH-1:0] OUT8,
  output logic [BITWIDTH-1:0] OUT9,
  output logic [BITWIDTH-1:0] OUT10,
  output logic [BITWIDTH-1:0] OUT11,
  output logic [BITWIDTH-1:0] OUT12,
  output logic [BITWIDTH-1:0] OUT13,
  output logic [BITWIDTH-1:0] OUT14,
  output logic [BITWIDTH-1:0] OUT15,
  output logic                STARVE
);
  localparam logic [3:0] MAX = 4'(MAX_STALL);
  logic [BITWIDTH-1:0] regs [16];
  logic [BITWIDTH-1:0] outv [16];
  logic [3:0]          stall_cnt;
  logic                a_xfer, b_xfer, wen;
  logic [3:0]          waddr;
  logic [BITWIDTH-1:0] wdata;
  assign STARVE  = stall_cnt == MAX;
  assign A_READY = !(B_VALID && STARVE);
  assign B_READY = !A_VALID || STARVE;
  assign a_xfer  = A_VALID && A_READY;
  assign b_xfer  = B_VALID && B_READY;
  assign wen     = !RST && (a_xfer || b_xfer);
  assign waddr   = b_xfer ? B_ADDR : A_ADDR;
  assign wdata   = b_xfer ? B_DATA : A_DATA;
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
      regs[15]  <= RESET_PC;
      stall_cnt <= '0;
    end else begin
      if (wen) regs[waddr] <= wdata;
      if (PC_INC && !(wen && waddr == 4'd15)) regs[15] <= regs[15] + BITWIDTH'(4);
      stall_cnt <= (B_VALID && !B_READY) ? (STARVE ? stall_cnt : stall_cnt + 4'd1) : '0;
    end
  end
  always_comb begin
    for (int i = 0; i < 16; i++) begin
`ifdef REGWR_WRITETHRU_EN
      outv[i] = (wen && waddr == 4'(i)) ? wdata : regs[i];
`else
      outv[i] = regs[i];
`endif
    end
  end
  assign OUT0  = outv[0];
  assign OUT1  = outv[1];
  assign OUT2  = outv[2];
  assign OUT3  = outv[3];
  assign OUT4  = outv[4];
  assign OUT5  = outv[5];
  assign OUT6  = outv[6];
  assign OUT7  = outv[7];
  assign OUT8  = outv[8];
  assign OUT9  = outv[9];
  assign OUT10 = outv[10];
  assign OUT11 = outv[11];
  assign OUT12 = outv[12];
  assign OUT13 = outv[13];
  assign OUT14 = outv[14];
  assign OUT15 = outv[15];
endmodule

// File: tb/tb_regfile_wrport.sv
// tb_regfile_wrport: directed table, corner sequences and random traffic against a register-array model
module tb_regfile_wrport;
  localparam int W = 32;
  localparam logic [W-1:0] RPC = 32'hFFFF_FFF8;
  localparam int MS = 3;
`ifdef REGWR_WRITETHRU_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RST, A_VALID, B_VALID, PC_INC, A_READY, B_READY, STARVE;
  logic [3:0] A_ADDR, B_ADDR;
  logic [W-1:0] A_DATA, B_DATA;
  logic [W-1:0] outs [16];
  regfile_wrport #(.BITWIDTH(W), .RESET_PC(RPC), .MAX_STALL(MS)) dut (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
    .PC_INC(PC_INC),
    .OUT0(outs[0]), .OUT1(outs[1]), .OUT2(outs[2]), .OUT3(outs[3]),
    .OUT4(outs[4]), .OUT5(outs[5]), .OUT6(outs[6]), .OUT7(outs[7]),
    .OUT8(outs[8]), .OUT9(outs[9]), .OUT10(outs[10]), .OUT11(outs[11]),
    .OUT12(outs[12]), .OUT13(outs[13]), .OUT14(outs[14]), .OUT15(outs[15]),
    .STARVE(STARVE)
  );
  always #5 CLK = ~CLK;
  logic [W-1:0] m [16];
  int cnt;
  int n_checks = 0;
  int n_fail = 0;
  logic s_ar, s_br, s_st;
  logic [W-1:0] s_pre [16];
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 15; i++) m[i] = '0;
    m[15] = RPC;
    cnt = 0;
  endtask
  task automatic cycle(input logic rst, input logic av, input logic [3:0] aa, input logic [W-1:0] ad,
                       input logic bv, input logic [3:0] ba, input logic [W-1:0] bd, input logic pc);
    logic st, ar, br, ax, bx;
    logic [3:0] wa;
    logic [W-1:0] wd, e;
    RST = rst; A_VALID = av; A_ADDR = aa; A_DATA = ad;
    B_VALID = bv; B_ADDR = ba; B_DATA = bd; PC_INC = pc;
    #1;
    st = cnt == MS;
    ar = !(bv && st);
    br = !av || st;
    ax = !rst && av && ar;
    bx = !rst && bv && br;
    wa = ax ? aa : ba;
    wd = ax ? ad : bd;
    s_ar = A_READY; s_br = B_READY; s_st = STARVE;
    chk("a_ready", W'(A_READY), W'(ar));
    chk("b_ready", W'(B_READY), W'(br));
    for (int i = 0; i < 16; i++) begin
      e = (WT && (ax || bx) && wa == 4'(i)) ? wd : m[i];
      s_pre[i] = outs[i];
      chk($sformatf("out%0d_pre", i), outs[i], e);
    end
    @(posedge CLK);
    #1;
    if (rst) model_reset();
    else begin
      if (ax || bx) m[wa] = wd;
      if (pc && !((ax || bx) && wa == 4'd15)) m[15] = m[15] + 4;
      cnt = (bv && !br) ? (cnt < MS ? cnt + 1 : MS) : 0;
    end
    for (int i = 0; i < 16; i++) chk($sformatf("out%0d", i), outs[i], m[i]);
    chk("starve", W'(STARVE), W'(cnt == MS));
  endtask
  typedef struct {
    logic av; logic [3:0] aa; logic [W-1:0] ad;
    logic bv; logic [3:0] ba; logic [W-1:0] bd;
    logic pc; logic ear; logic ebr; logic est;
    logic [3:0] ca; logic [W-1:0] cv;
  } vec_t;
  vec_t tbl [13];
  logic ha, hb, av, bv, pc, rst;
  logic [3:0] aa, ba;
  logic [W-1:0] ad, bd;
  initial begin
    tbl[0]  = '{1'b1, 4'd5,  32'h1234_5678, 1'b0, 4'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 4'd5,  32'h1234_5678};
    tbl[1]  = '{1'b1, 4'd1,  32'h11,        1'b1, 4'd7,  32'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1,  32'h11};
    tbl[2]  = '{1'b1, 4'd2,  32'h22,        1'b1, 4'd7,  32'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2,  32'h22};
    tbl[3]  = '{1'b1, 4'd3,  32'h33,        1'b1, 4'd7,  32'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3,  32'h33};
    tbl[4]  = '{1'b1, 4'd4,  32'h44,        1'b1, 4'd7,  32'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7,  32'hBEEF};
    tbl[5]  = '{1'b1, 4'd4,  32'h44,        1'b0, 4'd0,  32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 4'd4,  32'h44};
    tbl[6]  = '{1'b1, 4'd2,  32'h1,         1'b1, 4'd2,  32'h2,    1'b0, 1'b1, 1'b0, 1'b0, 4'd2,  32'h1};
    tbl[7]  = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd2,  32'h2,    1'b0, 1'b1, 1'b1, 1'b0, 4'd2,  32'h2};
    tbl[8]  = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,    1'b1, 1'b1, 1'b1, 1'b0, 4'd15, 32'hFFFF_FFFC};
    tbl[9]  = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,    1'b1, 1'b1, 1'b1, 1'b0, 4'd15, 32'h0};
    tbl[10] = '{1'b1, 4'd15, 32'h100,       1'b0, 4'd0,  32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 32'h100};
    tbl[11] = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,    1'b1, 1'b1, 1'b1, 1'b0, 4'd15, 32'h104};
    tbl[12] = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd15, 32'h200,  1'b1, 1'b1, 1'b1, 1'b0, 4'd15, 32'h200};
    RST = 1'b1; A_VALID = 1'b0; B_VALID = 1'b0; PC_INC = 1'b0;
    A_ADDR = '0; B_ADDR = '0; A_DATA = '0; B_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    repeat (3) cycle(1'b0, 1'b1, 4'd3, 32'h55, 1'b1, 4'd7, 32'hBEEF, 1'b0);
    chk("prereset_starve", W'(STARVE), W'(1'b1));
    repeat (2) cycle(1'b1, 1'b1, 4'd3, 32'hDEAD, 1'b0, 4'd0, 32'h0, 1'b1);
    chk("rst_out3", outs[3], 32'h0);
    chk("rst_pc", outs[15], RPC);
    chk("rst_starve", W'(STARVE), 32'h0);
    cycle(1'b0, 1'b0, 4'd3, 32'hDEAD, 1'b0, 4'd0, 32'h0, 1'b0);
    chk("post_rst_out3", outs[3], 32'h0);
    for (int k = 0; k < 13; k++) begin
      cycle(1'b0, tbl[k].av, tbl[k].aa, tbl[k].ad, tbl[k].bv, tbl[k].ba, tbl[k].bd, tbl[k].pc);
      chk($sformatf("v%0d_a_ready", k), W'(s_ar), W'(tbl[k].ear));
      chk($sformatf("v%0d_b_ready", k), W'(s_br), W'(tbl[k].ebr));
      chk($sformatf("v%0d_starve", k), W'(s_st), W'(tbl[k].est));
      chk($sformatf("v%0d_out%0d", k, tbl[k].ca), outs[tbl[k].ca], tbl[k].cv);
    end
    cycle(1'b0, 1'b1, 4'd9, 32'hCAFE, 1'b0, 4'd0, 32'h0, 1'b0);
    chk("wt_same_cycle", s_pre[9], WT ? 32'hCAFE : 32'h0);
    chk("wt_next_cycle", outs[9], 32'hCAFE);
    ha = 1'b0; hb = 1'b0;
    av = 1'b0; bv = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int k = 0; k < 400; k++) begin
      rst = $urandom_range(0, 60) == 0;
      if (!ha) begin
        av = $urandom_range(0, 2) != 0;
        aa = $urandom_range(0, 3) == 0 ? 4'd15 : 4'($urandom_range(0, 15));
        ad = $urandom;
      end
      if (!hb) begin
        bv = $urandom_range(0, 2) != 0;
        ba = $urandom_range(0, 3) == 0 ? 4'd15 : 4'($urandom_range(0, 15));
        bd = $urandom;
      end
      pc = $urandom_range(0, 1) == 1;
      cycle(rst, av, aa, ad, bv, ba, bd, pc);
      ha = !rst && av && !s_ar;
      hb = !rst && bv && !s_br;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
